// File: rtl/irq_ctrl_pkg.sv
// +----------------------------------------------------------------------+
// | irq_ctrl_pkg : shared FSM state type, defaults and ID-width helper    |
// | Revision     : 1.0                                                    |
// +----------------------------------------------------------------------+
`default_nettype none

package irq_ctrl_pkg;

   localparam int NUM_SRC_DEF = 4;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PENDING = 2'd1,
      ST_ACTIVE  = 2'd2
   } state_t;

   function automatic int id_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/irq_prio_enc.sv
// +----------------------------------------------------------------------+
// | irq_prio_enc : combinational lowest-index priority encoder + any flag |
// | Revision     : 1.0                                                    |
// +----------------------------------------------------------------------+
`default_nettype none

module irq_prio_enc
   import irq_ctrl_pkg::*;
#(
   parameter int NUM_SRC = NUM_SRC_DEF,
   parameter int ID_W    = id_width(NUM_SRC)
) (
   input  logic [NUM_SRC-1:0] req,
   output logic               any_req,
   output logic [ID_W-1:0]    id
);

   // Scan from the top down so the last hit, the lowest index, wins.
   always_comb begin
      id = '0;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (req[i]) begin
            id = ID_W'(i);
         end
      end
   end

   assign any_req = |req;

endmodule

`default_nettype wire

// File: rtl/irq_ctrl.sv
// +----------------------------------------------------------------------+
// | irq_ctrl : pulse-collecting interrupt controller, claim/complete FSM  |
// | Revision : 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module irq_ctrl
   import irq_ctrl_pkg::*;
#(
   parameter int NUM_SRC = NUM_SRC_DEF,
   parameter int DROP_W  = 8
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [NUM_SRC-1:0]          irq_in,
   input  logic                        mask_we,
   input  logic [NUM_SRC-1:0]          mask_wdata,
   output logic                        irq_out,
   input  logic                        claim,
   output logic                        claim_valid,
   output logic [id_width(NUM_SRC)-1:0] claim_id,
   output logic                        claim_spurious,
   input  logic                        complete,
   output logic [DROP_W-1:0]           drop_count,
   input  logic                        drop_clr
);

   localparam int ID_W  = id_width(NUM_SRC);
   localparam int SUM_W = DROP_W + 5;

   state_t               r_state;
   logic [NUM_SRC-1:0]   r_pending;
   logic [NUM_SRC-1:0]   r_mask;

   logic [NUM_SRC-1:0]   w_eligible;
   logic                 w_any_elig;
   logic [ID_W-1:0]      w_win_id;
   logic                 w_grant;
   logic [NUM_SRC-1:0]   w_clear;
   logic [NUM_SRC-1:0]   w_drops;
   logic [4:0]           w_drop_num;
   logic [SUM_W-1:0]     w_drop_sum;
   logic [DROP_W-1:0]    w_drop_next;

   assign w_eligible = r_pending & ~r_mask;

   irq_prio_enc #(
      .NUM_SRC (NUM_SRC),
      .ID_W    (ID_W)
   ) u_prio_enc (
      .req     (w_eligible),
      .any_req (w_any_elig),
      .id      (w_win_id)
   );

   // A claim in PENDING that finds nothing eligible (masked that same
   // cycle) is answered as spurious and the FSM falls back to IDLE.
   assign w_grant = claim && (r_state == ST_PENDING) && w_any_elig;
   assign w_clear = w_grant ? (NUM_SRC'(1) << w_win_id) : '0;

   // A pulse on the bit being claimed re-arms it rather than counting as lost.
   assign w_drops = irq_in & r_pending & ~w_clear;

   always_comb begin
      w_drop_num = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         w_drop_num = w_drop_num + 5'(w_drops[i]);
      end
      w_drop_sum = SUM_W'(drop_count) + SUM_W'(w_drop_num);
      if (w_drop_sum > SUM_W'({DROP_W{1'b1}})) begin
         w_drop_next = '1;
      end else begin
         w_drop_next = w_drop_sum[DROP_W-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state        <= ST_IDLE;
         r_pending      <= '0;
         r_mask         <= '1;
         drop_count     <= '0;
         irq_out        <= 1'b0;
         claim_valid    <= 1'b0;
         claim_id       <= '0;
         claim_spurious <= 1'b0;
      end else begin
         if (mask_we) begin
            r_mask <= mask_wdata;
         end
         r_pending <= (r_pending & ~w_clear) | irq_in;
         drop_count <= drop_clr ? '0 : w_drop_next;

         claim_valid    <= claim;
         claim_id       <= w_grant ? w_win_id : '0;
         claim_spurious <= claim && !w_grant;

         case (r_state)
            ST_IDLE: begin
               if (w_any_elig) begin
                  r_state <= ST_PENDING;
                  irq_out <= 1'b1;
               end else begin
                  irq_out <= 1'b0;
               end
            end
            ST_PENDING: begin
               if (w_grant) begin
                  r_state <= ST_ACTIVE;
                  irq_out <= 1'b0;
               end else if (!w_any_elig) begin
                  r_state <= ST_IDLE;
                  irq_out <= 1'b0;
               end else begin
                  irq_out <= 1'b1;
               end
            end
            ST_ACTIVE: begin
               irq_out <= 1'b0;
               if (complete) begin
                  r_state <= ST_IDLE;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               irq_out <= 1'b0;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_irq_ctrl.sv
// +----------------------------------------------------------------------+
// | tb_irq_ctrl : directed + randomized bench with behavioural model      |
// | Revision    : 1.0                                                     |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_irq_ctrl;

   localparam int N  = 4;
   localparam int DW = 8;
   localparam int DROP_MAX = (1 << DW) - 1;

   logic           clk = 1'b0;
   logic           rst_n;
   logic [N-1:0]   irq_in;
   logic           mask_we;
   logic [N-1:0]   mask_wdata;
   logic           irq_out;
   logic           claim;
   logic           claim_valid;
   logic [1:0]     claim_id;
   logic           claim_spurious;
   logic           complete;
   logic [DW-1:0]  drop_count;
   logic           drop_clr;

   irq_ctrl #(
      .NUM_SRC (N),
      .DROP_W  (DW)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .irq_in         (irq_in),
      .mask_we        (mask_we),
      .mask_wdata     (mask_wdata),
      .irq_out        (irq_out),
      .claim          (claim),
      .claim_valid    (claim_valid),
      .claim_id       (claim_id),
      .claim_spurious (claim_spurious),
      .complete       (complete),
      .drop_count     (drop_count),
      .drop_clr       (drop_clr)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Model: phase 0 = quiet, 1 = host being interrupted, 2 = host servicing.
   bit m_pend [N];
   bit m_mask [N];
   int m_phase;
   bit m_irq, m_cv, m_csp;
   int m_cid, m_drop;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_step();
      int  lowest;
      int  lost;
      bit  granted;
      if (!rst_n) begin
         for (int i = 0; i < N; i++) begin
            m_pend[i] = 1'b0;
            m_mask[i] = 1'b1;
         end
         m_phase = 0; m_irq = 0; m_cv = 0; m_csp = 0; m_cid = 0; m_drop = 0;
      end else begin
         lowest = -1;
         for (int i = 0; i < N; i++)
            if (lowest < 0 && m_pend[i] && !m_mask[i]) lowest = i;
         granted = claim && (m_phase == 1) && (lowest >= 0);
         m_cv  = claim;
         m_cid = granted ? lowest : 0;
         m_csp = claim && !granted;
         case (m_phase)
            0: if (lowest >= 0) m_phase = 1;
            1: if (granted) m_phase = 2; else if (lowest < 0) m_phase = 0;
            default: if (complete) m_phase = 0;
         endcase
         m_irq = (m_phase == 1);
         lost = 0;
         for (int i = 0; i < N; i++) begin
            if (irq_in[i] && m_pend[i] && !(granted && i == lowest)) lost++;
            if (granted && i == lowest) m_pend[i] = 1'b0;
            if (irq_in[i]) m_pend[i] = 1'b1;
         end
         if (drop_clr) m_drop = 0;
         else m_drop = (m_drop + lost > DROP_MAX) ? DROP_MAX : m_drop + lost;
         if (mask_we)
            for (int i = 0; i < N; i++) m_mask[i] = mask_wdata[i];
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      model_step();
      @(negedge clk);
      chk("irq_out",        32'(irq_out),        32'(m_irq));
      chk("claim_valid",    32'(claim_valid),    32'(m_cv));
      chk("claim_id",       32'(claim_id),       32'(m_cid));
      chk("claim_spurious", 32'(claim_spurious), 32'(m_csp));
      chk("drop_count",     32'(drop_count),     32'(m_drop));
   endtask

   task automatic clr_in();
      rst_n = 1'b1; irq_in = '0; mask_we = 1'b0; mask_wdata = '0;
      claim = 1'b0; complete = 1'b0; drop_clr = 1'b0;
   endtask

   task automatic write_mask(input logic [N-1:0] m);
      mask_we = 1'b1; mask_wdata = m;
      cycle();
      mask_we = 1'b0;
   endtask

   initial begin
      clr_in();
      rst_n = 1'b0;
      cycle(); cycle();
      rst_n = 1'b1;
      chk("rst_irq_out", 32'(irq_out), 0);
      chk("rst_claim_valid", 32'(claim_valid), 0);
      chk("rst_claim_id", 32'(claim_id), 0);
      chk("rst_claim_spurious", 32'(claim_spurious), 0);
      chk("rst_drop_count", 32'(drop_count), 0);

      // Single pulse latency and claim
      write_mask(4'b0000);
      irq_in = 4'b0100; cycle(); irq_in = '0;
      chk("lat_n1_irq", 32'(irq_out), 0);
      cycle();
      chk("lat_n2_irq", 32'(irq_out), 1);
      cycle();
      claim = 1'b1; cycle(); claim = 1'b0;
      chk("c2_valid", 32'(claim_valid), 1);
      chk("c2_id", 32'(claim_id), 2);
      chk("c2_irq", 32'(irq_out), 0);
      complete = 1'b1; cycle(); complete = 1'b0; cycle();

      // Two simultaneous sources, lowest index first
      irq_in = 4'b1010; cycle(); irq_in = '0; cycle();
      claim = 1'b1; cycle(); claim = 1'b0;
      chk("two_first_id", 32'(claim_id), 1);
      complete = 1'b1; cycle(); complete = 1'b0; cycle();
      claim = 1'b1; cycle(); claim = 1'b0;
      chk("two_second_id", 32'(claim_id), 3);
      complete = 1'b1; cycle(); complete = 1'b0;
      chk("two_drop", 32'(drop_count), 0);

      // Masked pulse, then unmask
      clr_in(); rst_n = 1'b0; cycle(); rst_n = 1'b1;
      irq_in = 4'b0001; cycle(); irq_in = '0; cycle(); cycle();
      chk("masked_irq", 32'(irq_out), 0);
      write_mask(4'b0000);
      chk("unmask_w1_irq", 32'(irq_out), 0);
      cycle();
      chk("unmask_w2_irq", 32'(irq_out), 1);
      claim = 1'b1; cycle(); claim = 1'b0;
      chk("unmask_id", 32'(claim_id), 0);
      complete = 1'b1; cycle(); complete = 1'b0;

      // Repeated pulses and pulse coincident with claim
      irq_in = 4'b0001; cycle(); cycle(); cycle(); irq_in = '0;
      chk("drop_two", 32'(drop_count), 2);
      claim = 1'b1; irq_in = 4'b0001; cycle(); claim = 1'b0; irq_in = '0;
      chk("coinc_id", 32'(claim_id), 0);
      chk("coinc_drop", 32'(drop_count), 2);
      complete = 1'b1; cycle(); complete = 1'b0; cycle();
      chk("coinc_rearmed_irq", 32'(irq_out), 1);
      claim = 1'b1; cycle(); claim = 1'b0;
      chk("coinc_reclaim_id", 32'(claim_id), 0);
      chk("coinc_reclaim_spur", 32'(claim_spurious), 0);
      complete = 1'b1; cycle(); complete = 1'b0;

      // Spurious claim in IDLE, then drop saturation and clear
      claim = 1'b1; cycle(); claim = 1'b0;
      chk("spur_valid", 32'(claim_valid), 1);
      chk("spur_flag", 32'(claim_spurious), 1);
      chk("spur_id", 32'(claim_id), 0);
      write_mask(4'b1111);
      irq_in = 4'b0001;
      repeat (301) cycle();
      irq_in = '0;
      chk("drop_sat", 32'(drop_count), 255);
      drop_clr = 1'b1; cycle(); drop_clr = 1'b0;
      chk("drop_clr", 32'(drop_count), 0);

      // Reset while servicing with other sources pending
      write_mask(4'b0000); cycle();
      claim = 1'b1; cycle(); claim = 1'b0;
      chk("svc_id", 32'(claim_id), 0);
      irq_in = 4'b0011; cycle(); irq_in = '0;
      rst_n = 1'b0; complete = 1'b1; cycle(); rst_n = 1'b1;
      chk("midrst_irq", 32'(irq_out), 0);
      chk("midrst_valid", 32'(claim_valid), 0);
      chk("midrst_drop", 32'(drop_count), 0);
      cycle(); complete = 1'b0;
      write_mask(4'b0000); cycle(); cycle();
      chk("midrst_discard_irq", 32'(irq_out), 0);
      claim = 1'b1; cycle(); claim = 1'b0;
      chk("midrst_spur", 32'(claim_spurious), 1);

      // Randomized traffic against the model
      clr_in();
      for (int c = 0; c < 4000; c++) begin
         for (int i = 0; i < N; i++) irq_in[i] = ($urandom_range(0, 7) == 0);
         mask_we    = ($urandom_range(0, 19) == 0);
         mask_wdata = N'($urandom & $urandom);
         claim      = ($urandom_range(0, 3) == 0);
         complete   = ($urandom_range(0, 3) == 0);
         drop_clr   = ($urandom_range(0, 63) == 0);
         rst_n      = ($urandom_range(0, 399) != 0);
         cycle();
      end
      clr_in();
      cycle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
